// File: rtl/cone_response_misr.sv
// Response-compaction stage: folds cone output vectors into a Galois MISR and
// compares the final signature against a golden value after num_vec beats.
module cone_response_misr #(
  parameter int unsigned          OUT_W  = 8,
  parameter int unsigned          MISR_W = 16,
  parameter int unsigned          CNT_W  = 16,
  parameter logic [MISR_W-1:0]    POLY   = 16'hB400,
  parameter logic [MISR_W-1:0]    SEED   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [MISR_W-1:0] golden,
  input  logic              resp_valid,
  input  logic [OUT_W-1:0]  resp_data,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  num_q;
  logic [MISR_W-1:0] golden_q;
  logic [MISR_W-1:0] data_ext;
  logic [MISR_W-1:0] sig_n;
  logic [CNT_W-1:0]  count_inc;
  logic              accept;
  logic              last_beat;
  logic              start_take;
  logic              zero_run;

  assign data_ext   = MISR_W'(resp_data);
  assign sig_n      = (signature >> 1) ^ (signature[0] ? POLY : '0) ^ data_ext;
  assign count_inc  = vec_count + 1'b1;
  assign accept     = (state == RUN) && resp_valid;
  assign last_beat  = accept && (count_inc == num_q);
  // start is only honoured outside RUN; a zero-length run completes immediately
  assign start_take = start && (state != RUN);
  assign zero_run   = (num_vec == '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_n = zero_run ? DONE : RUN;
      end
      RUN: begin
        if (last_beat) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      signature <= SEED;
      vec_count <= '0;
      pass      <= 1'b0;
      num_q     <= '0;
      golden_q  <= '0;
    end else begin
      state <= state_n;
      if (start_take) begin
        signature <= SEED;
        vec_count <= '0;
        num_q     <= num_vec;
        golden_q  <= golden;
        pass      <= zero_run && (golden == SEED);
      end else if (accept) begin
        signature <= sig_n;
        vec_count <= count_inc;
        if (last_beat) pass <= (sig_n == golden_q);
      end
    end
  end

  always_comb begin
    resp_ready = (state == RUN);
    busy       = (state == RUN);
    done       = (state == DONE);
  end

endmodule

// File: tb/tb_cone_response_misr.sv
// Bench for cone_response_misr: table vectors, hand sequences, and random runs
// against an arithmetic MISR model.
module tb_cone_response_misr;

  localparam logic [15:0] POLY = 16'hB400;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic [15:0] golden;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] vec_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cone_response_misr #(
    .OUT_W (8),
    .MISR_W(16),
    .CNT_W (16),
    .POLY  (16'hB400),
    .SEED  (16'hFFFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vec   (num_vec),
    .golden    (golden),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_ready(resp_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .vec_count (vec_count)
  );

  // Reference MISR step using plain integer arithmetic on the signature value.
  function automatic int unsigned model_step(input int unsigned sig, input int unsigned d);
    int unsigned shifted;
    shifted = sig / 2;
    if (sig % 2 == 1) shifted = shifted ^ 32'hB400;
    return (shifted ^ d) % 65536;
  endfunction

  function automatic logic [15:0] model_sig(input logic [7:0] d[$]);
    int unsigned s;
    s = SEED;
    foreach (d[i]) s = model_step(s, d[i]);
    return s[15:0];
  endfunction

  // Original cone: 8-bit sum of the two input bytes.
  function automatic logic [7:0] cone_orig(input logic [15:0] x);
    int unsigned s;
    s = (x[7:0] + x[15:8]) % 256;
    return s[7:0];
  endfunction

  // Optimized cone: ripple-carry expansion of the same sum.
  function automatic logic [7:0] cone_opt(input logic [15:0] x);
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[i] ^ x[i+8] ^ c;
      c    = (x[i] & x[i+8]) | (c & (x[i] ^ x[i+8]));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] nv, input logic [15:0] g);
    start      = 1'b1;
    num_vec    = nv;
    golden     = g;
    resp_valid = 1'b0;
    tick();
    start   = 1'b0;
    num_vec = $urandom_range(65535);
    golden  = $urandom_range(65535);
  endtask

  task automatic feed(input logic [7:0] d, input bit v, output bit acc);
    resp_valid = v;
    resp_data  = d;
    acc        = v && resp_ready;
    tick();
    resp_valid = 1'b0;
    resp_data  = $urandom_range(255);
  endtask

  task automatic run_seq(input int nv, input logic [15:0] g, input logic [7:0] d[$],
                         input int gap_pct, input logic [15:0] exp_sig, input bit exp_pass);
    int accepted;
    int cycles;
    bit acc;
    bit v;
    do_start(nv[15:0], g);
    check("start_busy", busy, nv != 0);
    check("start_done", done, nv == 0);
    accepted = 0;
    cycles   = 0;
    while (accepted < nv && cycles < 1000) begin
      v = ($urandom_range(99) >= gap_pct);
      feed(d[accepted], v, acc);
      if (acc) accepted++;
      cycles++;
    end
    check("beats", accepted, nv);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("ready_end", resp_ready, 0);
    check("vec_count", vec_count, nv);
    check("signature", signature, exp_sig);
    check("pass", pass, exp_pass);
    feed(8'h5A, 1'b1, acc);
    check("no_extra_acc", acc, 0);
    check("frozen_sig", signature, exp_sig);
    check("frozen_cnt", vec_count, nv);
    check("frozen_pass", pass, exp_pass);
  endtask

  typedef struct {
    int          nv;
    logic [15:0] g;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] exp_sig;
    bit          exp_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0]  dq[$];
    logic [7:0]  dq2[$];
    logic [15:0] xs[$];
    logic [15:0] s_orig;
    logic [15:0] s_opt;
    logic [15:0] g;
    bit          acc;
    int          n;
    int          cnt;
    bit          pat[7];

    rst = 1'b1; start = 1'b0; num_vec = '0; golden = '0;
    resp_valid = 1'b0; resp_data = '0;
    tick(); tick();
    check("rst_ready", resp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig", signature, 16'hFFFF);
    check("rst_cnt", vec_count, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", resp_ready, 0);

    vecs[0] = '{1, 16'hCBFF, 8'h00, 8'h00, 16'hCBFF, 1'b1};
    vecs[1] = '{1, 16'hCBFF, 8'h01, 8'h00, 16'hCBFE, 1'b0};
    vecs[2] = '{2, 16'hD1FF, 8'h00, 8'h00, 16'hD1FF, 1'b1};
    vecs[3] = '{0, 16'hFFFF, 8'h00, 8'h00, 16'hFFFF, 1'b1};
    vecs[4] = '{0, 16'h1234, 8'h00, 8'h00, 16'hFFFF, 1'b0};
    vecs[5] = '{2, 16'h0000, 8'h00, 8'h01, 16'hD1FE, 1'b0};
    foreach (vecs[i]) begin
      dq = {vecs[i].d0, vecs[i].d1};
      run_seq(vecs[i].nv, vecs[i].g, dq, 0, vecs[i].exp_sig, vecs[i].exp_pass);
    end

    // Zero-length run keeps resp_ready low for several cycles.
    do_start(16'd0, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      check("zero_ready", resp_ready, 0);
      check("zero_cnt", vec_count, 0);
      check("zero_pass", pass, 1);
      tick();
    end

    // Gapped beats: valid pattern 1,0,0,1,1,0,1 for num_vec=4.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    dq  = {8'h11, 8'h22, 8'h33, 8'h44};
    do_start(16'd4, model_sig(dq));
    cnt = 0;
    foreach (pat[i]) begin
      feed(dq[cnt % 4], pat[i], acc);
      if (acc) cnt++;
    end
    check("gap_beats", cnt, 4);
    check("gap_cnt", vec_count, 4);
    check("gap_sig", signature, model_sig(dq));
    check("gap_pass", pass, 1);
    check("gap_done", done, 1);

    // Reset mid-run at vec_count=2.
    do_start(16'd5, 16'h0);
    feed(8'h12, 1'b1, acc);
    feed(8'h34, 1'b1, acc);
    check("mid_cnt", vec_count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_sig", signature, 16'hFFFF);
    check("mr_cnt", vec_count, 0);
    check("mr_done", done, 0);
    check("mr_busy", busy, 0);
    check("mr_ready", resp_ready, 0);
    check("mr_pass", pass, 0);
    tick();
    check("mr_idle_busy", busy, 0);

    // start pulsed during RUN is ignored.
    dq = {8'hA1, 8'hB2, 8'hC3};
    do_start(16'd3, model_sig(dq));
    feed(dq[0], 1'b1, acc);
    start = 1'b1; num_vec = 16'd1; golden = 16'h0000;
    feed(dq[1], 1'b1, acc);
    start = 1'b0;
    check("ign_busy", busy, 1);
    check("ign_cnt", vec_count, 2);
    feed(dq[2], 1'b1, acc);
    check("ign_done", done, 1);
    check("ign_cnt3", vec_count, 3);
    check("ign_pass", pass, 1);
    check("ign_sig", signature, model_sig(dq));
    // start in DONE restarts; done drops with the restart.
    do_start(16'd2, 16'h0);
    check("rs_done", done, 0);
    check("rs_busy", busy, 1);
    check("rs_cnt", vec_count, 0);
    check("rs_sig", signature, 16'hFFFF);
    check("rs_pass", pass, 0);
    rst = 1'b1; tick(); rst = 1'b0;

    // 256 vectors from original vs optimized cones, then a single flipped bit.
    dq = {}; dq2 = {}; xs = {};
    for (int i = 0; i < 256; i++) begin
      xs.push_back($urandom_range(65535));
      dq.push_back(cone_orig(xs[i]));
      dq2.push_back(cone_opt(xs[i]));
    end
    g = model_sig(dq);
    run_seq(256, g, dq, 20, g, 1'b1);
    s_orig = signature;
    run_seq(256, g, dq2, 20, g, 1'b1);
    s_opt = signature;
    check("cone_equiv", s_opt, s_orig);
    n = $urandom_range(255);
    dq2[n] = dq2[n] ^ (8'h01 << $urandom_range(7));
    run_seq(256, g, dq2, 0, model_sig(dq2), 1'b0);

    // Randomized runs against the model.
    for (int r = 0; r < 20; r++) begin
      n  = $urandom_range(12, 1);
      dq = {};
      for (int i = 0; i < n; i++) dq.push_back($urandom_range(255));
      g = ($urandom_range(1) == 1) ? model_sig(dq) : 16'($urandom_range(65535));
      run_seq(n, g, dq, 40, model_sig(dq), g == model_sig(dq));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
